// File: rtl/row_op_sequencer.sv
// Row-operation sequencer: expands one dst = dst OP src command into registered
// per-row select / write / FA-op pulses and returns carry and overflow flags.
//
// state | meaning
// IDLE  | ready for a command; clr_carry honoured here only
// LOAD  | source drives up bus, destination takes down-path operand
// EXEC  | selects held, write pulse and FA op asserted; flags sampled on exit
// DONE  | response valid until accepted; no row activity
module row_op_sequencer #(
    parameter int M  = 16,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [2:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_src_i,
    input  logic [AW-1:0] cmd_dst_i,
    input  logic          clr_carry_i,
    output logic [M-1:0]  rd_sel_up_o,
    output logic [M-1:0]  rd_sel_dn_o,
    output logic [M-1:0]  wr_sel_up_o,
    output logic [M-1:0]  wr_sel_dn_o,
    output logic [M-1:0]  wr_en_o,
    output logic [3:0]    op_fa_o,
    output logic          first_carry_o,
    input  logic [M-1:0]  overflow_i,
    input  logic [M-1:0]  last_carry_in_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic          rsp_c_o,
    output logic          rsp_v_o,
    output logic          rsp_err_o,
    output logic          busy_o
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_ADC = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic          carry_q, carry_d;
    logic          rsp_c_q, rsp_c_d;
    logic          rsp_v_q, rsp_v_d;
    logic          rsp_err_q, rsp_err_d;

    logic [M-1:0]  rd_sel_up_q, rd_sel_up_d;
    logic [M-1:0]  wr_sel_dn_q, wr_sel_dn_d;
    logic [M-1:0]  wr_en_q, wr_en_d;
    logic [3:0]    op_fa_q, op_fa_d;
    logic          first_carry_q, first_carry_d;
    logic          cmd_ready_q, busy_q, rsp_valid_q;

    logic          cmd_legal;
    logic          is_arith;
    logic          ov_dst;
    logic          lci_dst;

    // Out-of-range indices decode to all-zero, so no row is ever selected twice.
    function automatic logic [M-1:0] onehot(input logic [AW-1:0] idx);
        logic [M-1:0] v;
        v = '0;
        for (int i = 0; i < M; i++) begin
            v[i] = (32'(idx) == 32'(i));
        end
        return v;
    endfunction

    assign cmd_legal = (cmd_op_i <= OP_ADC)
                     && (32'(cmd_src_i) < 32'(M))
                     && (32'(cmd_dst_i) < 32'(M));
    assign is_arith  = (op_q == OP_ADD) || (op_q == OP_ADC);
    assign ov_dst    = |(overflow_i & onehot(dst_q));
    assign lci_dst   = |(last_carry_in_i & onehot(dst_q));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        carry_d   = carry_q;
        rsp_c_d   = rsp_c_q;
        rsp_v_d   = rsp_v_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                // Clear applies before an ADC accepted on the same edge reads the flag.
                if (clr_carry_i) carry_d = 1'b0;
                if (cmd_valid_i) begin
                    op_d  = cmd_op_i;
                    src_d = cmd_src_i;
                    dst_d = cmd_dst_i;
                    if (cmd_legal) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d   = S_DONE;
                        rsp_c_d   = 1'b0;
                        rsp_v_d   = 1'b0;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: state_d = S_EXEC;
            S_EXEC: begin
                state_d   = S_DONE;
                rsp_err_d = 1'b0;
                if (is_arith) begin
                    rsp_c_d = ov_dst;
                    rsp_v_d = ov_dst ^ lci_dst;
                    carry_d = ov_dst;
                end else begin
                    rsp_c_d = 1'b0;
                    rsp_v_d = 1'b0;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Row controls are decoded from the next state so the rows see them on entry.
    always_comb begin
        rd_sel_up_d   = '0;
        wr_sel_dn_d   = '0;
        wr_en_d       = '0;
        op_fa_d       = '0;
        first_carry_d = 1'b0;
        if (state_d == S_LOAD || state_d == S_EXEC) begin
            rd_sel_up_d = onehot(src_d);
            wr_sel_dn_d = onehot(dst_d);
        end
        if (state_d == S_EXEC) begin
            wr_en_d = onehot(dst_d);
            case (op_d)
                OP_ADD, OP_ADC: op_fa_d = 4'b0001;
                OP_AND:         op_fa_d = 4'b0010;
                OP_XOR:         op_fa_d = 4'b0100;
                OP_OR:          op_fa_d = 4'b1000;
                default:        op_fa_d = 4'b0000;
            endcase
            first_carry_d = (op_d == OP_ADC) && carry_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            op_q          <= OP_ADD;
            src_q         <= '0;
            dst_q         <= '0;
            carry_q       <= 1'b0;
            rsp_c_q       <= 1'b0;
            rsp_v_q       <= 1'b0;
            rsp_err_q     <= 1'b0;
            rd_sel_up_q   <= '0;
            wr_sel_dn_q   <= '0;
            wr_en_q       <= '0;
            op_fa_q       <= '0;
            first_carry_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            carry_q       <= carry_d;
            rsp_c_q       <= rsp_c_d;
            rsp_v_q       <= rsp_v_d;
            rsp_err_q     <= rsp_err_d;
            rd_sel_up_q   <= rd_sel_up_d;
            wr_sel_dn_q   <= wr_sel_dn_d;
            wr_en_q       <= wr_en_d;
            op_fa_q       <= op_fa_d;
            first_carry_q <= first_carry_d;
            cmd_ready_q   <= (state_d == S_IDLE);
            busy_q        <= (state_d != S_IDLE);
            rsp_valid_q   <= (state_d == S_DONE);
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign busy_o        = busy_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_c_o       = rsp_c_q;
    assign rsp_v_o       = rsp_v_q;
    assign rsp_err_o     = rsp_err_q;
    assign rd_sel_up_o   = rd_sel_up_q;
    assign wr_sel_dn_o   = wr_sel_dn_q;
    assign wr_en_o       = wr_en_q;
    assign op_fa_o       = op_fa_q;
    assign first_carry_o = first_carry_q;
    assign rd_sel_dn_o   = '0;
    assign wr_sel_up_o   = '0;

endmodule
